// File: rtl/lsu_axi_bridge.sv
// lsu_axi_bridge
//   Bridges the core's valid/ready memory request onto an AXI4 master port.
//   Only one transaction is in flight at a time. Reads may be bursts of up to
//   256 beats. Writes are always a single beat. Each read beat, or the write
//   completion, comes back on a registered one-cycle response pulse.
//
// Ports
//   clk, reset                      clock; synchronous active-high reset
//   req_*                           core request (valid/ready, wen, addr, len, wdata, wstrb)
//   resp_valid/resp_data/resp_last  registered response beat
//   ar_*, rd_*                      AXI read address / read data channels
//   aw_*, wd_*, wstrb, wr_*         AXI write address / data / response channels
//
// Configuration
//   AXI_TIMEOUT_EN   When defined, a watchdog counter aborts a transaction that
//                    sees no AXI handshake for TIMEOUT cycles. The bridge then
//                    returns a 64'hDEAD_BEEF_DEAD_BEEF response with resp_last=1.
module lsu_axi_bridge #(
  parameter int TIMEOUT_W = 8,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [7:0]  req_len,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wstrb,
  output logic        resp_valid,
  output logic [63:0] resp_data,
  output logic        resp_last,
  output logic        ar_valid,
  input  logic        ar_ready,
  output logic [63:0] ar_addr,
  output logic [7:0]  ar_len,
  input  logic        rd_valid,
  output logic        rd_ready,
  input  logic [63:0] rd_data,
  input  logic        rd_last,
  output logic        aw_valid,
  input  logic        aw_ready,
  output logic [63:0] aw_addr,
  output logic        wd_valid,
  input  logic        wd_ready,
  output logic [63:0] wd_data,
  output logic [7:0]  wstrb,
  output logic        wd_last,
  input  logic        wr_valid,
  output logic        wr_ready
);

  if (TIMEOUT >= (1 << TIMEOUT_W)) begin : g_bad_timeout
    $error("lsu_axi_bridge: TIMEOUT does not fit in TIMEOUT_W bits");
  end

  typedef enum logic [2:0] {IDLE, AR, R, W, B} state_t;

  typedef struct packed {
    logic [63:0] addr;
    logic [7:0]  len;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
  } req_t;

  state_t state, state_nxt;
  req_t   lat;
  logic   aw_done, w_done;
  logic   aw_hs, w_hs;
  logic   abort;

  assign aw_hs = aw_valid && aw_ready;
  assign w_hs  = wd_valid && wd_ready;

  // Address/data outputs come straight from the latched request, so they
  // stay stable for the whole transaction regardless of the slave's ready.
  assign ar_addr = lat.addr;
  assign ar_len  = lat.len;
  assign aw_addr = lat.addr;
  assign wd_data = lat.wdata;
  assign wstrb   = lat.wstrb;
  assign wd_last = 1'b1;

`ifdef AXI_TIMEOUT_EN
  logic                 any_hs;
  logic [TIMEOUT_W-1:0] wdog;

  assign any_hs = (ar_valid && ar_ready) || (rd_valid && rd_ready) || aw_hs || w_hs ||
                  (wr_valid && wr_ready);

  always_ff @(posedge clk) begin
    if (reset || state == IDLE || any_hs) wdog <= '0;
    else                                  wdog <= wdog + 1'b1;
  end

  assign abort = (state != IDLE) && (wdog == TIMEOUT_W'(TIMEOUT));
`else
  assign abort = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    ar_valid  = 1'b0;
    rd_ready  = 1'b0;
    aw_valid  = 1'b0;
    wd_valid  = 1'b0;
    wr_ready  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_wen ? W : AR;
      end
      AR: begin
        ar_valid = 1'b1;
        if (ar_ready) state_nxt = R;
      end
      R: begin
        rd_ready = 1'b1;
        if (rd_valid && rd_last) state_nxt = IDLE;
      end
      W: begin
        // Address and data channels complete independently; move on once
        // both have handshaken, whether earlier or in this cycle.
        aw_valid = !aw_done;
        wd_valid = !w_done;
        if ((aw_done || aw_hs) && (w_done || w_hs)) state_nxt = B;
      end
      B: begin
        wr_ready = 1'b1;
        if (wr_valid) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (abort) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      lat        <= '0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_last  <= 1'b0;
    end else begin
      state      <= state_nxt;
      resp_valid <= 1'b0;
      if (state == IDLE && req_valid)
        lat <= '{addr: req_addr, len: req_len, wdata: req_wdata, wstrb: req_wstrb};
      // Done flags live only while in W; leaving W clears them for the next write.
      if (state == W && state_nxt == W) begin
        aw_done <= aw_done || aw_hs;
        w_done  <= w_done || w_hs;
      end else begin
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (abort) begin
        resp_valid <= 1'b1;
        resp_data  <= 64'hDEAD_BEEF_DEAD_BEEF;
        resp_last  <= 1'b1;
      end else if (state == R && rd_valid) begin
        resp_valid <= 1'b1;
        resp_data  <= rd_data;
        resp_last  <= rd_last;
      end else if (state == B && wr_valid) begin
        resp_valid <= 1'b1;
        resp_data  <= '0;
        resp_last  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_axi_bridge.sv
// tb_lsu_axi_bridge
//   Bench for lsu_axi_bridge. The bench contains an AXI SRAM slave with random
//   ready/valid timing. It also holds a reference model: a plain word-addressed
//   memory plus an expected-response queue, filled when each request is issued.
//   There is a directed vector table, hand-written sequences for stall, latency
//   and mid-burst reset, and a randomized back-to-back request phase.
module tb_lsu_axi_bridge;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_wen = 1'b0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic [7:0]  req_len = '0, req_wstrb = '0;
  logic        resp_valid, resp_last;
  logic [63:0] resp_data;
  logic        ar_valid, ar_ready = 1'b0;
  logic [63:0] ar_addr;
  logic [7:0]  ar_len;
  logic        rd_valid = 1'b0, rd_ready, rd_last = 1'b0;
  logic [63:0] rd_data = '0;
  logic        aw_valid, aw_ready = 1'b0;
  logic [63:0] aw_addr;
  logic        wd_valid, wd_ready = 1'b0, wd_last;
  logic [63:0] wd_data;
  logic [7:0]  wstrb;
  logic        wr_valid = 1'b0, wr_ready;

  always #5 clk = ~clk;

  lsu_axi_bridge #(.TIMEOUT_W(8), .TIMEOUT(255)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
    .req_len(req_len), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last),
    .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_addr(aw_addr),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wstrb(wstrb), .wd_last(wd_last),
    .wr_valid(wr_valid), .wr_ready(wr_ready)
  );

  int checks = 0, errors = 0;

  typedef struct { logic [63:0] data; logic last; } beat_t;
  beat_t exp_q[$];
  beat_t got_q[$];
  beat_t mon_e;

  logic [63:0] mem     [logic [63:0]];
  logic [63:0] ref_mem [logic [63:0]];

  // current request, used to check the AXI address/data channels
  logic [63:0] cur_addr = '0, cur_wd = '0;
  logic [7:0]  cur_len = '0, cur_ws = '0;

  // slave controls
  int ar_hold = 0;
  bit aw_stuck = 1'b0;
  bit fast = 1'b0;

  function automatic logic [63:0] pat(input logic [63:0] a);
    return {a[31:0] ^ 32'hA5A5_A5A5, a[31:0]};
  endfunction
  function automatic logic [63:0] slv_rd(input logic [63:0] a);
    if (mem.exists(a)) return mem[a];
    return pat(a);
  endfunction
  function automatic logic [63:0] ref_rd(input logic [63:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return pat(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- AXI SRAM slave ----------------
  logic [63:0] s_raddr = '0, s_awaddr = '0, s_wd = '0;
  logic [7:0]  s_ws = '0;
  int          s_rleft = 0;
  bit          s_rbusy = 0, s_aw_got = 0, s_w_got = 0, s_bpend = 0, r_hs = 0, b_hs = 0;

  // Record handshakes at the edge where they happen.
  always @(posedge clk) begin
    if (reset) begin
      s_rbusy = 0; s_aw_got = 0; s_w_got = 0; s_bpend = 0; r_hs = 0; b_hs = 0;
    end else begin
      r_hs = rd_valid && rd_ready;
      b_hs = wr_valid && wr_ready;
      if (r_hs) begin
        s_raddr = s_raddr + 64'd8;
        s_rleft--;
        if (s_rleft == 0) s_rbusy = 0;
      end
      if (ar_valid && ar_ready) begin
        s_rbusy = 1; s_raddr = ar_addr; s_rleft = int'(ar_len) + 1;
      end
      if (aw_valid && aw_ready) begin s_aw_got = 1; s_awaddr = aw_addr; end
      if (wd_valid && wd_ready) begin s_w_got = 1; s_wd = wd_data; s_ws = wstrb; end
      if (b_hs) s_bpend = 0;
      if (s_aw_got && s_w_got) begin
        logic [63:0] w;
        w = slv_rd(s_awaddr);
        for (int b = 0; b < 8; b++) if (s_ws[b]) w[8*b +: 8] = s_wd[8*b +: 8];
        mem[s_awaddr] = w;
        s_aw_got = 0; s_w_got = 0; s_bpend = 1;
      end
    end
  end

  // Drive slave outputs mid-cycle; a valid is held until its handshake.
  always @(negedge clk) begin
    if (ar_hold > 0) begin ar_ready = 1'b0; ar_hold--; end
    else ar_ready = fast || ($urandom_range(0, 3) != 0);
    aw_ready = !aw_stuck && (fast || ($urandom_range(0, 2) != 0));
    wd_ready = fast || ($urandom_range(0, 2) != 0);
    if (!s_rbusy) rd_valid = 1'b0;
    else if (!(rd_valid && !r_hs)) rd_valid = fast || ($urandom_range(0, 3) != 0);
    rd_data = s_rbusy ? slv_rd(s_raddr) : 64'd0;
    rd_last = s_rbusy && (s_rleft == 1);
    if (!s_bpend) wr_valid = 1'b0;
    else if (!(wr_valid && !b_hs)) wr_valid = fast || ($urandom_range(0, 1) == 1);
  end

  // ---------------- response / channel monitor ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (resp_valid) begin
        got_q.push_back('{resp_data, resp_last});
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_resp: got data %h last %0b, expected no response", resp_data, resp_last);
        end else begin
          mon_e = exp_q.pop_front();
          chk("resp_data", resp_data, mon_e.data);
          chk("resp_last", 64'(resp_last), 64'(mon_e.last));
        end
      end
      if (ar_valid) begin
        chk("ar_addr", ar_addr, cur_addr);
        chk("ar_len", 64'(ar_len), 64'(cur_len));
      end
      if (aw_valid) chk("aw_addr", aw_addr, cur_addr);
      if (wd_valid) begin
        chk("wd_data", wd_data, cur_wd);
        chk("wstrb", 64'(wstrb), 64'(cur_ws));
        chk("wd_last", 64'(wd_last), 64'd1);
      end
    end
  end

  // ---------------- driver + reference model ----------------
  task automatic issue(input bit wen, input logic [63:0] addr, input logic [7:0] len,
                       input logic [63:0] wd, input logic [7:0] ws, input bit expect_abort);
    int n = 0;
    @(negedge clk);
    while (!req_ready && n < 1000) begin @(negedge clk); n++; end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL req_ready_wait: got 0 expected 1");
      return;
    end
    cur_addr = addr; cur_len = len; cur_wd = wd; cur_ws = ws;
    if (expect_abort) exp_q.push_back('{64'hDEAD_BEEF_DEAD_BEEF, 1'b1});
    else if (wen) begin
      logic [63:0] w;
      w = ref_rd(addr);
      for (int b = 0; b < 8; b++) if (ws[b]) w[8*b +: 8] = wd[8*b +: 8];
      ref_mem[addr] = w;
      exp_q.push_back('{64'd0, 1'b1});
    end else begin
      for (int i = 0; i <= int'(len); i++)
        exp_q.push_back('{ref_rd(addr + 64'(8 * i)), i == int'(len)});
    end
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_len = len;
    req_wdata = wd; req_wstrb = ws;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || !req_ready) && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (exp_q.size() != 0 || !req_ready) begin
      errors++;
      $display("FAIL %s_done: %0d responses outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  typedef struct {
    bit          wen;
    logic [63:0] addr;
    logic [7:0]  len;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    int          beats;
    logic [63:0] d_first;
    logic [63:0] d_last;
  } vec_t;
  vec_t tbl[4];

  initial begin
    int n, nl, base;
    tbl[0] = '{0, 64'h8000_0000, 8'd0, 64'd0, 8'h00, 1, 64'h25A5A5A5_80000000, 64'h25A5A5A5_80000000};
    tbl[1] = '{0, 64'h8000_0100, 8'd3, 64'd0, 8'h00, 4, 64'h25A5A4A5_80000100, 64'h25A5A4BD_80000118};
    tbl[2] = '{1, 64'h8000_0008, 8'd0, 64'h1122334455667788, 8'h0F, 1, 64'd0, 64'd0};
    tbl[3] = '{0, 64'h8000_0008, 8'd0, 64'd0, 8'h00, 1, 64'h25A5A5AD_55667788, 64'h25A5A5AD_55667788};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_handshake_outs", 64'({ar_valid, rd_ready, aw_valid, wd_valid, wr_ready, resp_valid, req_ready}), 64'h01);
    chk("rst_resp_data", resp_data, 64'd0);
    chk("rst_ar_addr", ar_addr, 64'd0);
    chk("rst_aw_addr", aw_addr, 64'd0);
    reset = 1'b0;

    // directed vector table
    for (int i = 0; i < 4; i++) begin
      got_q.delete();
      issue(tbl[i].wen, tbl[i].addr, tbl[i].len, tbl[i].wdata, tbl[i].wstrb, 1'b0);
      wait_done($sformatf("vec%0d", i));
      chk($sformatf("vec%0d_beats", i), 64'(got_q.size()), 64'(tbl[i].beats));
      if (got_q.size() > 0) begin
        chk($sformatf("vec%0d_first", i), got_q[0].data, tbl[i].d_first);
        chk($sformatf("vec%0d_lastdata", i), got_q[got_q.size()-1].data, tbl[i].d_last);
        chk($sformatf("vec%0d_lastflag", i), 64'(got_q[got_q.size()-1].last), 64'd1);
        nl = 0;
        foreach (got_q[k]) nl += int'(got_q[k].last);
        chk($sformatf("vec%0d_nlast", i), 64'(nl), 64'd1);
      end
    end

    // minimum read latency with an always-ready slave
    fast = 1'b1;
    issue(0, 64'h8000_0020, 8'd0, 64'd0, 8'h00, 1'b0);
    @(negedge clk);
    chk("lat_resp_c2", 64'(resp_valid), 64'd0);
    @(negedge clk);
    chk("lat_resp_c3", 64'(resp_valid), 64'd1);
    wait_done("latency");
    fast = 1'b0;

    // address channel stall: ar_ready held low
    ar_hold = 12;
    issue(0, 64'h8000_0040, 8'd1, 64'd0, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("stall_ar_valid", 64'(ar_valid), 64'd1);
      chk("stall_ar_addr", ar_addr, 64'h8000_0040);
      chk("stall_req_ready", 64'(req_ready), 64'd0);
      @(negedge clk);
    end
    wait_done("stall");

    // reset in the middle of a 4-beat burst
    got_q.delete();
    issue(0, 64'h8000_0200, 8'd3, 64'd0, 8'h00, 1'b0);
    n = 0;
    while (got_q.size() < 2 && n < 500) begin @(negedge clk); n++; end
    chk("midrst_two_beats", 64'(got_q.size() >= 2), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_outs", 64'({ar_valid, rd_ready, aw_valid, wd_valid, wr_ready, resp_valid, req_ready}), 64'h01);
    exp_q.delete();
    reset = 1'b0;
    base = got_q.size();
    repeat (10) @(negedge clk);
    chk("midrst_no_more_resp", 64'(got_q.size()), 64'(base));

    // randomized back-to-back traffic
    for (int t = 0; t < 40; t++) begin
      bit          w;
      logic [63:0] a;
      w = ($urandom_range(0, 2) == 0);
      a = 64'h8000_0000 + 64'(8 * $urandom_range(0, 63));
      issue(w, a, 8'($urandom_range(0, 7)), {$urandom, $urandom}, 8'($urandom_range(0, 255)), 1'b0);
    end
    wait_done("random");

`ifdef AXI_TIMEOUT_EN
    aw_stuck = 1'b1;
    issue(1, 64'h8000_0300, 8'd0, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b1);
    wait_done("timeout");
    chk("timeout_idle", 64'(req_ready), 64'd1);
    aw_stuck = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
`endif

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("FAIL global_timeout: simulation did not complete, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
